binoc_link_dir_ctrl: RTL and testbench
======================================

// Module: binoc_link_dir_ctrl
// PURPOSE
//  Direction controller for one inter-router link of the BiNoC mesh. Owns NUM_CH bidirectional
//  channels between end A (west/south router) and end B (east/north router).
//  Per channel, decides which end may drive, with a dead-cycle turnaround and anti-ping-pong hold.
//  Instantiated once per link in the mesh top, replacing per-router HP/LP req/gnt wiring.
// PARAMETERS
//  NUM_CH    4  bidirectional channels on the link (>=2)
//  TURN_CYC  2  dead cycles per direction change, during which neither end drives (>=1)
//  HOLD_CYC  4  min cycles a channel stays with a new owner before it can be reclaimed (>=0)
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    synchronous active-high reset
//  a_demand   in   $clog2(NUM_CH+1)     channels end A wants; values >NUM_CH saturate to NUM_CH
//  b_demand   in   $clog2(NUM_CH+1)     channels end B wants; values >NUM_CH saturate to NUM_CH
//  a_busy     in   NUM_CH               A mid-packet on ch i; ignored unless A owns ch i
//  b_busy     in   NUM_CH               B mid-packet on ch i; ignored unless B owns ch i
//  a_own      out  NUM_CH               A may drive ch i (tri-state enable)
//  b_own      out  NUM_CH               B may drive ch i (tri-state enable)
//  a_cnt      out  $clog2(NUM_CH+1)     channels committed to A (OWN_A plus TURN toward A)
//  b_cnt      out  $clog2(NUM_CH+1)     channels committed to B
//  switch_evt out  1                    1-cycle pulse when a channel enters turnaround
// BEHAVIOUR
//  Per-channel states: OWN_A, OWN_B, TURN_TO_A, TURN_TO_B.
//  Reset: even i -> OWN_A, odd i -> OWN_B; hold counters 0; turn counters 0; prio=A.
//   Outputs then: a_own=..0101, b_own=..1010, a_cnt=ceil(N/2), b_cnt=floor(N/2), switch_evt=0.
//  a_own[i]=1 only in OWN_A; b_own[i]=1 only in OWN_B. Both 0 in TURN. Never both 1.
//  A hungry: sat(a_demand) > a_cnt. B hungry: sat(b_demand) > b_cnt.
//  Eligible for A: ch in OWN_B, b_busy[i]=0, hold counter expired. Symmetric for B.
//  Each cycle, at most one channel is switched: the lowest-index eligible ch for the winning side.
//  Both sides hungry with eligible chs -> prio side wins; prio toggles after every switch.
//  One side hungry with an eligible ch -> that side wins; prio unchanged.
//  Decision at edge t: ch enters TURN_TO_x at t+1.
//   Old own bit falls at t+1. Committed count moves to x at t+1. switch_evt=1 during t+1.
//  TURN lasts exactly TURN_CYC cycles, then OWN_x. New own bit rises at t+1+TURN_CYC.
//   Hold counter loads HOLD_CYC on that same edge.
//  Hold counter decrements in OWN state to 0. Ch is reclaimable only when its hold counter is 0.
//  TURN chs are never eligible; demand changes during TURN do not abort it.
//  A busy bit rising in the same cycle as a decision blocks that ch. Lowest non-busy ch is taken.
//  a_cnt+b_cnt == NUM_CH always. No side is ever starved below its demand if the other side is idle.
//  rst asserted mid-turnaround: next edge returns all chs to reset assignment; in-flight turns drop.
// STRUCTURE
//  binoc_pkg: typedef enum logic[1:0] ch_state_e {OWN_A,OWN_B,TURN_TO_A,TURN_TO_B};
//   also cnt_t width helper and the even/odd initial-owner function.
//  Sub-module binoc_ch_fsm (one per channel, generate loop).
//   Holds state plus turn/hold counters. Inputs: take_a, take_b. Outputs: state, eligible_a, eligible_b.
//  Top level holds the popcount, hungry compare, lowest-index pick and prio flop.
// TESTING (NUM_CH=4, TURN_CYC=2, HOLD_CYC=4)
//  1 Reset, demands 2/2 for 20 cycles -> a_own=0101, b_own=1010, a_cnt=b_cnt=2, switch_evt never 1.
//  2 a_demand=3, b_demand=0, b_busy=0000, at edge t.
//    -> ch1 goes TURN_TO_A: b_own=1000 at t+1.
//    -> a_own=0111 at t+3; a_cnt=3 from t+1; single switch_evt pulse.
//  3 Then b_demand=4 immediately -> ch1 not reclaimable until 4 cycles after t+3.
//    -> ch0 (hold 0, lowest eligible) switches first, then ch2, then ch1 once its hold expires.
//  4 Both hungry: a_demand=4, b_demand=4, no busy bits.
//    -> switches alternate A,B,A,... per prio; a_own & b_own == 0 every cycle.
//  5 a_demand=4, b_busy=1010 -> no switch while busy. Clear b_busy[1] -> ch1 goes to A, not ch3.
//  6 rst pulsed in second TURN cycle of ch1 -> next cycle a_own=0101, b_own=1010, counts 2/2.

Source files
------------

// File: rtl/binoc_pkg.sv
// Shared types and helpers for the BiNoC link direction controller.
package binoc_pkg;

  typedef enum logic [1:0] {
    OWN_A     = 2'd0,
    OWN_B     = 2'd1,
    TURN_TO_A = 2'd2,
    TURN_TO_B = 2'd3
  } ch_state_e;

  // Width of a channel count that must hold 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Reset owner: even channels start with end A, odd channels with end B.
  function automatic ch_state_e init_owner(input int unsigned idx);
    return ((idx % 2) == 1) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/binoc_ch_fsm.sv
// One bidirectional channel: owner state, turnaround counter and anti-ping-pong hold counter.
module binoc_ch_fsm
  import binoc_pkg::*;
#(
  parameter int unsigned TURN_CYC   = 2,
  parameter int unsigned HOLD_CYC   = 4,
  parameter ch_state_e   INIT_STATE = OWN_A
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_take_a,
  input  logic      i_take_b,
  input  logic      i_a_busy,
  input  logic      i_b_busy,
  output ch_state_e o_state,
  output logic      o_eligible_a,
  output logic      o_eligible_b
);

  localparam int unsigned TW = $clog2(TURN_CYC + 1);
  localparam int unsigned HW = $clog2(HOLD_CYC + 2);

  ch_state_e      r_state;
  ch_state_e      w_state_nxt;
  logic [TW-1:0]  r_turn;
  logic [TW-1:0]  w_turn_nxt;
  logic [HW-1:0]  r_hold;
  logic [HW-1:0]  w_hold_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_STATE;
      r_turn  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_turn  <= w_turn_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Turn counter runs TURN_CYC-1 down to 0, so the channel spends exactly TURN_CYC cycles dead.
  always_comb begin
    w_state_nxt = r_state;
    w_turn_nxt  = r_turn;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      OWN_A: begin
        if (i_take_b) begin
          w_state_nxt = TURN_TO_B;
          w_turn_nxt  = TW'(TURN_CYC - 1);
        end else if (r_hold != '0) begin
          w_hold_nxt = r_hold - HW'(1);
        end
      end
      OWN_B: begin
        if (i_take_a) begin
          w_state_nxt = TURN_TO_A;
          w_turn_nxt  = TW'(TURN_CYC - 1);
        end else if (r_hold != '0) begin
          w_hold_nxt = r_hold - HW'(1);
        end
      end
      TURN_TO_A: begin
        if (r_turn == '0) begin
          w_state_nxt = OWN_A;
          w_hold_nxt  = HW'(HOLD_CYC);
        end else begin
          w_turn_nxt = r_turn - TW'(1);
        end
      end
      TURN_TO_B: begin
        if (r_turn == '0) begin
          w_state_nxt = OWN_B;
          w_hold_nxt  = HW'(HOLD_CYC);
        end else begin
          w_turn_nxt = r_turn - TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_state      = r_state;
    o_eligible_a = 1'b0;
    o_eligible_b = 1'b0;
    if (r_hold == '0) begin
      o_eligible_a = (r_state == OWN_B) && !i_b_busy;
      o_eligible_b = (r_state == OWN_A) && !i_a_busy;
    end
  end

endmodule

// File: rtl/binoc_link_dir_ctrl.sv
// Link direction controller: arbitrates channel ownership between end A and end B of one link.
module binoc_link_dir_ctrl
  import binoc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [cnt_w(NUM_CH)-1:0]   a_demand,
  input  logic [cnt_w(NUM_CH)-1:0]   b_demand,
  input  logic [NUM_CH-1:0]          a_busy,
  input  logic [NUM_CH-1:0]          b_busy,
  output logic [NUM_CH-1:0]          a_own,
  output logic [NUM_CH-1:0]          b_own,
  output logic [cnt_w(NUM_CH)-1:0]   a_cnt,
  output logic [cnt_w(NUM_CH)-1:0]   b_cnt,
  output logic                       switch_evt
);

  localparam int unsigned CW = cnt_w(NUM_CH);

  ch_state_e         w_state [NUM_CH];
  logic [NUM_CH-1:0] w_elig_a;
  logic [NUM_CH-1:0] w_elig_b;
  logic [NUM_CH-1:0] w_take_a;
  logic [NUM_CH-1:0] w_take_b;
  logic [NUM_CH-1:0] w_pick_a;
  logic [NUM_CH-1:0] w_pick_b;
  logic [CW-1:0]     w_a_cnt;
  logic [CW-1:0]     w_b_cnt;
  logic [CW-1:0]     w_a_sat;
  logic [CW-1:0]     w_b_sat;
  logic              w_try_a;
  logic              w_try_b;
  logic              w_contest;
  logic              w_a_win;
  logic              w_b_win;
  logic              r_prio_b;
  logic              r_switch_evt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    binoc_ch_fsm #(
      .TURN_CYC   (TURN_CYC),
      .HOLD_CYC   (HOLD_CYC),
      .INIT_STATE (init_owner(i))
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_take_a     (w_take_a[i]),
      .i_take_b     (w_take_b[i]),
      .i_a_busy     (a_busy[i]),
      .i_b_busy     (b_busy[i]),
      .o_state      (w_state[i]),
      .o_eligible_a (w_elig_a[i]),
      .o_eligible_b (w_elig_b[i])
    );
  end

  // Own decode and committed counts (a channel turning toward x already counts for x).
  always_comb begin
    a_own   = '0;
    b_own   = '0;
    w_a_cnt = '0;
    w_b_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      a_own[i] = (w_state[i] == OWN_A);
      b_own[i] = (w_state[i] == OWN_B);
      w_a_cnt  = w_a_cnt + CW'((w_state[i] == OWN_A) || (w_state[i] == TURN_TO_A));
      w_b_cnt  = w_b_cnt + CW'((w_state[i] == OWN_B) || (w_state[i] == TURN_TO_B));
    end
  end

  // Hungry compare, arbitration and lowest-index one-hot pick (x & -x).
  always_comb begin
    w_a_sat   = (a_demand > CW'(NUM_CH)) ? CW'(NUM_CH) : a_demand;
    w_b_sat   = (b_demand > CW'(NUM_CH)) ? CW'(NUM_CH) : b_demand;
    w_try_a   = (w_a_sat > w_a_cnt) && (w_elig_a != '0);
    w_try_b   = (w_b_sat > w_b_cnt) && (w_elig_b != '0);
    w_contest = w_try_a && w_try_b;
    w_a_win   = w_contest ? !r_prio_b : w_try_a;
    w_b_win   = w_contest ?  r_prio_b : w_try_b;
    w_pick_a  = w_elig_a & (~w_elig_a + NUM_CH'(1));
    w_pick_b  = w_elig_b & (~w_elig_b + NUM_CH'(1));
    w_take_a  = w_a_win ? w_pick_a : '0;
    w_take_b  = w_b_win ? w_pick_b : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_b     <= 1'b0;
      r_switch_evt <= 1'b0;
    end else begin
      if (w_contest) begin
        r_prio_b <= !r_prio_b;
      end
      r_switch_evt <= w_a_win || w_b_win;
    end
  end

  assign a_cnt      = w_a_cnt;
  assign b_cnt      = w_b_cnt;
  assign switch_evt = r_switch_evt;

endmodule

// File: tb/tb_binoc_link_dir_ctrl.sv
// Directed bench for binoc_link_dir_ctrl (NUM_CH=4, TURN_CYC=2, HOLD_CYC=4).
module tb_binoc_link_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] a_demand, b_demand;
  logic [3:0] a_busy, b_busy;
  logic [3:0] a_own, b_own;
  logic [2:0] a_cnt, b_cnt;
  logic       switch_evt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  binoc_link_dir_ctrl #(.NUM_CH(4), .TURN_CYC(2), .HOLD_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_demand   (a_demand),
    .b_demand   (b_demand),
    .a_busy     (a_busy),
    .b_busy     (b_busy),
    .a_own      (a_own),
    .b_own      (b_own),
    .a_cnt      (a_cnt),
    .b_cnt      (b_cnt),
    .switch_evt (switch_evt)
  );

  // Inputs applied during one cycle; expected outputs in the cycle after the next edge.
  typedef struct {
    logic       rst;
    logic [2:0] a_dem;
    logic [2:0] b_dem;
    logic [3:0] a_busy;
    logic [3:0] b_busy;
    logic [3:0] e_a_own;
    logic [3:0] e_b_own;
    logic [2:0] e_a_cnt;
    logic [2:0] e_b_cnt;
    logic       e_sw;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] ad, input logic [2:0] bd,
                     input logic [3:0] ab, input logic [3:0] bb,
                     input logic [3:0] ea, input logic [3:0] eb,
                     input logic [2:0] eac, input logic [2:0] ebc, input logic es);
    vec_t v;
    v.rst = r; v.a_dem = ad; v.b_dem = bd; v.a_busy = ab; v.b_busy = bb;
    v.e_a_own = ea; v.e_b_own = eb; v.e_a_cnt = eac; v.e_b_cnt = ebc; v.e_sw = es;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] ea, input logic [3:0] eb,
                         input logic [2:0] eac, input logic [2:0] ebc, input logic es);
    chk("a_own", idx, a_own, ea);
    chk("b_own", idx, b_own, eb);
    chk("a_cnt", idx, {1'b0, a_cnt}, {1'b0, eac});
    chk("b_cnt", idx, {1'b0, b_cnt}, {1'b0, ebc});
    chk("switch_evt", idx, {3'b0, switch_evt}, {3'b0, es});
  endtask

  task automatic drive(input logic r, input logic [2:0] ad, input logic [2:0] bd,
                       input logic [3:0] ab, input logic [3:0] bb);
    rst = r; a_demand = ad; b_demand = bd; a_busy = ab; b_busy = bb;
    @(negedge clk);
  endtask

  initial begin
    // Balanced demand after reset: nothing moves.
    drive(1'b1, 3'd2, 3'd2, 4'b0000, 4'b0000);
    chk_all(0, 4'b0101, 4'b1010, 3'd2, 3'd2, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 3'd2, 3'd2, 4'b0000, 4'b0000);
      chk_all(i, 4'b0101, 4'b1010, 3'd2, 3'd2, 1'b0);
    end

    // A takes ch1, then B (A idle) takes ch0, ch2, and ch1 only after its hold expires.
    add(1, 2, 2, 0, 0,       4'b0101, 4'b1010, 2, 2, 0);
    add(0, 3, 0, 0, 0,       4'b0101, 4'b1000, 3, 1, 1);
    add(0, 0, 4, 0, 0,       4'b0100, 4'b1000, 2, 2, 1);
    add(0, 0, 4, 0, 0,       4'b0010, 4'b1000, 1, 3, 1);
    add(0, 0, 4, 0, 0,       4'b0010, 4'b1001, 1, 3, 0);
    add(0, 0, 4, 0, 0,       4'b0010, 4'b1101, 1, 3, 0);
    add(0, 0, 4, 0, 0,       4'b0010, 4'b1101, 1, 3, 0);
    add(0, 0, 4, 0, 0,       4'b0010, 4'b1101, 1, 3, 0);
    add(0, 0, 4, 0, 0,       4'b0000, 4'b1101, 0, 4, 1);
    add(0, 0, 4, 0, 0,       4'b0000, 4'b1101, 0, 4, 0);
    add(0, 0, 4, 0, 0,       4'b0000, 4'b1111, 0, 4, 0);
    // Busy channels are not reclaimed; clearing b_busy[1] hands ch1 (not ch3) to A.
    add(1, 0, 0, 0, 0,       4'b0101, 4'b1010, 2, 2, 0);
    add(0, 4, 0, 0, 4'b1010, 4'b0101, 4'b1010, 2, 2, 0);
    add(0, 4, 0, 0, 4'b1010, 4'b0101, 4'b1010, 2, 2, 0);
    add(0, 4, 0, 0, 4'b1000, 4'b0101, 4'b1000, 3, 1, 1);
    add(0, 4, 0, 0, 4'b1000, 4'b0101, 4'b1000, 3, 1, 0);
    add(0, 4, 0, 0, 4'b1000, 4'b0111, 4'b1000, 3, 1, 0);
    // Reset during the second turnaround cycle drops the in-flight turn.
    add(1, 0, 0, 0, 0,       4'b0101, 4'b1010, 2, 2, 0);
    add(0, 3, 0, 0, 0,       4'b0101, 4'b1000, 3, 1, 1);
    add(0, 3, 0, 0, 0,       4'b0101, 4'b1000, 3, 1, 0);
    add(1, 3, 0, 0, 0,       4'b0101, 4'b1010, 2, 2, 0);
    add(0, 0, 0, 0, 0,       4'b0101, 4'b1010, 2, 2, 0);
    // Demand 7 saturates to 4: A ends with every channel, no more.
    add(0, 7, 0, 0, 0,       4'b0101, 4'b1000, 3, 1, 1);
    add(0, 7, 0, 0, 0,       4'b0101, 4'b0000, 4, 0, 1);
    add(0, 7, 0, 0, 0,       4'b0111, 4'b0000, 4, 0, 0);
    add(0, 7, 0, 0, 0,       4'b1111, 4'b0000, 4, 0, 0);
    // Both hungry: A ch1, B ch0, A ch3, then B ch2 (A has nothing eligible).
    add(1, 0, 0, 0, 0,       4'b0101, 4'b1010, 2, 2, 0);
    add(0, 4, 4, 0, 0,       4'b0101, 4'b1000, 3, 1, 1);
    add(0, 4, 4, 0, 0,       4'b0100, 4'b1000, 2, 2, 1);
    add(0, 4, 4, 0, 0,       4'b0110, 4'b0000, 3, 1, 1);
    add(0, 4, 4, 0, 0,       4'b0010, 4'b0001, 2, 2, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].a_dem, tbl[i].b_dem, tbl[i].a_busy, tbl[i].b_busy);
      chk_all(100 + i, tbl[i].e_a_own, tbl[i].e_b_own, tbl[i].e_a_cnt, tbl[i].e_b_cnt, tbl[i].e_sw);
    end

    // Sustained contention: ownership stays exclusive and counts always cover the link.
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 3'd4, 3'd4, 4'b0000, 4'b0000);
      chk("own_overlap", 200 + i, a_own & b_own, 4'b0000);
      chk("cnt_sum", 200 + i, 4'({1'b0, a_cnt} + {1'b0, b_cnt}), 4'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
